// File: rtl/huffman_bit_packer_if.sv
// Codeword-in / byte-out handshake bundle for huffman_bit_packer.
// master = codeword producer and byte consumer, slave = the packer.
interface huffman_bit_packer_if #(
  parameter int CODE_W = 8,
  parameter int LEN_W  = 4
);
  logic [CODE_W-1:0] code_in;
  logic [LEN_W-1:0]  length_in;
  logic              code_valid;
  logic              code_ready;
  logic              flush;
  logic [7:0]        byte_out;
  logic              byte_valid;
  logic              byte_ready;
  logic              flush_done;

  modport master (
    output code_in, length_in, code_valid, flush, byte_ready,
    input  code_ready, byte_out, byte_valid, flush_done
  );

  modport slave (
    input  code_in, length_in, code_valid, flush, byte_ready,
    output code_ready, byte_out, byte_valid, flush_done
  );
endinterface

// File: rtl/huffman_bit_packer.sv
// Packs variable-length Huffman codewords MSB-first into bytes, with zero-pad flush.
// Optional HUFF_PACK_STATS_EN adds wrapping total_bits / total_bytes counters.
module huffman_bit_packer #(
  parameter int CODE_W = 8,
  parameter int LEN_W  = 4,
  parameter int STAT_W = 24
) (
  input  logic                clock,
  input  logic                reset,
  huffman_bit_packer_if.slave bus
`ifdef HUFF_PACK_STATS_EN
  ,
  output logic [STAT_W-1:0]   total_bits,
  output logic [STAT_W-1:0]   total_bytes
`endif
);
  localparam int MW = CODE_W + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state;
  logic [15:0] acc;
  logic [4:0]  cnt;

  logic              free, emit, accept, pad, done;
  logic [4:0]        len_c, cnt_post, cnt_app, shamt;
  logic [MW-1:0]     mask;
  logic [CODE_W-1:0] code_m;
  logic [15:0]       acc_post, ins, acc_app;

  always_comb begin
    free   = !bus.byte_valid || bus.byte_ready;
    emit   = (cnt >= 5'd8) && free;
    pad    = (state == FLUSH) && (cnt != 5'd0) && (cnt < 5'd8) && free;
    done   = (state == FLUSH) && (cnt == 5'd0) && free;
    bus.code_ready = (state == RUN) && ((cnt < 5'd8) || emit);
    accept = bus.code_valid && bus.code_ready;

    len_c  = (bus.length_in > LEN_W'(CODE_W)) ? 5'(CODE_W) : 5'(bus.length_in);
    mask   = (MW'(1) << len_c) - MW'(1);
    code_m = bus.code_in & mask[CODE_W-1:0];

    acc_post = emit ? (acc << 8) : acc;
    cnt_post = emit ? (cnt - 5'd8) : cnt;
    // cnt_post <= 7 whenever a code is accepted, so shamt >= 1 and nothing falls off the top
    shamt    = 5'd16 - cnt_post - len_c;
    ins      = 16'(code_m) << shamt;
    acc_app  = accept ? (acc_post | ins) : acc_post;
    cnt_app  = accept ? (cnt_post + len_c) : cnt_post;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= RUN;
      acc            <= '0;
      cnt            <= '0;
      bus.byte_out   <= '0;
      bus.byte_valid <= 1'b0;
      bus.flush_done <= 1'b0;
    end else begin
      bus.flush_done <= 1'b0;
      acc            <= acc_app;
      cnt            <= cnt_app;

      if (emit || pad) begin
        bus.byte_out   <= acc[15:8];
        bus.byte_valid <= 1'b1;
      end else if (bus.byte_valid && bus.byte_ready) begin
        bus.byte_valid <= 1'b0;
      end

      case (state)
        RUN: if (bus.flush) begin
          // nothing buffered and output slot free: finish right away
          if ((cnt_app == 5'd0) && !emit && free) bus.flush_done <= 1'b1;
          else                                    state <= FLUSH;
        end
        FLUSH: begin
          if (pad) begin
            acc <= '0;
            cnt <= '0;
          end else if (done) begin
            bus.flush_done <= 1'b1;
            state          <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HUFF_PACK_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      total_bits  <= '0;
      total_bytes <= '0;
    end else begin
      if (accept)      total_bits  <= total_bits + STAT_W'(len_c);
      if (emit || pad) total_bytes <= total_bytes + STAT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed scenarios plus random traffic checked against a bit-queue model.
module tb_huffman_bit_packer;
  localparam int CODE_W = 8, LEN_W = 4, STAT_W = 24;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  huffman_bit_packer_if #(.CODE_W(CODE_W), .LEN_W(LEN_W)) bus ();
`ifdef HUFF_PACK_STATS_EN
  logic [STAT_W-1:0] total_bits, total_bytes;
`endif

  huffman_bit_packer #(.CODE_W(CODE_W), .LEN_W(LEN_W), .STAT_W(STAT_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef HUFF_PACK_STATS_EN
    ,
    .total_bits(total_bits),
    .total_bytes(total_bytes)
`endif
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference: queue of pending bits, earliest first; flush pads it to a byte boundary
  bit         bq[$];
  bit         mflush = 1'b0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_byte = '0;
  logic       obs_cr, obs_bv, obs_fd;
  logic [7:0] obs_bo;

  task automatic drive(input logic cv, input logic [7:0] code, input logic [3:0] len,
                       input logic fl, input logic br);
    bus.code_valid = cv;
    bus.code_in    = code;
    bus.length_in  = len;
    bus.flush      = fl;
    bus.byte_ready = br;
  endtask

  task automatic step();
    logic [7:0] exp_b;
    int l;
    #1;
    obs_cr = bus.code_ready;
    obs_bv = bus.byte_valid;
    obs_bo = bus.byte_out;
    obs_fd = bus.flush_done;
    if (reset) begin
      bq.delete();
      mflush    = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(obs_bv), 32'd1);
        chk("hold_byte", 32'(obs_bo), 32'(prev_byte));
      end
      if (obs_fd) begin
        chk("fd_in_flush", 32'(mflush), 32'd1);
        chk("fd_empty", 32'(bq.size()), 32'd0);
        mflush = 1'b0;
      end
      if (mflush) chk("ready_in_flush", 32'(obs_cr), 32'd0);
      if (obs_bv && bus.byte_ready) begin
        if (bq.size() < 8) chk("byte_underflow", 32'(bq.size()), 32'd8);
        else begin
          exp_b = '0;
          for (int i = 0; i < 8; i++) exp_b = {exp_b[6:0], bq.pop_front()};
          chk("byte_data", 32'(obs_bo), 32'(exp_b));
        end
      end
      if (bus.code_valid && obs_cr) begin
        l = (int'(bus.length_in) > CODE_W) ? CODE_W : int'(bus.length_in);
        for (int i = l - 1; i >= 0; i--) bq.push_back(bus.code_in[i]);
      end
      if (bus.flush && !mflush) begin
        mflush = 1'b1;
        while ((bq.size() % 8) != 0) bq.push_back(1'b0);
      end
      prev_hold = obs_bv && !bus.byte_ready;
      prev_byte = obs_bo;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 8'h00, 4'd0, 0, 1);
    step();
    reset = 1'b0;
  endtask

  task automatic t1();
    drive(1, 8'h05, 4'd3, 0, 1); step();
    drive(1, 8'h13, 4'd5, 0, 1); step();
    drive(0, 8'h00, 4'd0, 0, 1); step();
    chk("t1_bv_early", 32'(obs_bv), 32'd0);
    step();
    chk("t1_bv", 32'(obs_bv), 32'd1);
    chk("t1_byte", 32'(obs_bo), 32'hB3);
    step();
    chk("t1_bv_drop", 32'(obs_bv), 32'd0);
  endtask

  task automatic t3();
    drive(1, 8'h03, 4'd2, 0, 1); step();
    drive(0, 8'h00, 4'd0, 1, 1); step();
    drive(0, 8'h00, 4'd0, 0, 1); step();
    chk("t3_fd_early", 32'(obs_fd), 32'd0);
    step();
    chk("t3_bv", 32'(obs_bv), 32'd1);
    chk("t3_byte", 32'(obs_bo), 32'hC0);
    chk("t3_fd_with_byte", 32'(obs_fd), 32'd0);
    step();
    chk("t3_fd", 32'(obs_fd), 32'd1);
    step();
    chk("t3_fd_once", 32'(obs_fd), 32'd0);
  endtask

  initial begin
    logic [7:0] c1, c2, c3;
    int budget;
    drive(0, 8'h00, 4'd0, 0, 1);
    @(negedge clock);
    do_reset();

    drive(0, 8'h00, 4'd0, 0, 1); step();
    chk("rst_bv", 32'(obs_bv), 32'd0);
    chk("rst_byte", 32'(obs_bo), 32'd0);
    chk("rst_fd", 32'(obs_fd), 32'd0);
    chk("rst_cr", 32'(obs_cr), 32'd1);

    t1();

    drive(1, 8'hA5, 4'd8, 0, 1); step();
    chk("t2_cr0", 32'(obs_cr), 32'd1);
    drive(1, 8'h3C, 4'd8, 0, 1); step();
    chk("t2_cr1", 32'(obs_cr), 32'd1);
    drive(0, 8'h00, 4'd0, 0, 1); step();
    chk("t2_byte0", 32'(obs_bo), 32'hA5);
    step();
    chk("t2_bv1", 32'(obs_bv), 32'd1);
    chk("t2_byte1", 32'(obs_bo), 32'h3C);
    step();
    chk("t2_bv_drop", 32'(obs_bv), 32'd0);

    t3();

    c1 = 8'($urandom); c2 = 8'($urandom); c3 = 8'($urandom);
    drive(1, c1, 4'd8, 0, 0); step();
    chk("t4_cr_a", 32'(obs_cr), 32'd1);
    drive(1, c2, 4'd8, 0, 0); step();
    chk("t4_cr_b", 32'(obs_cr), 32'd1);
    drive(1, c3, 4'd8, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_cr_stall", 32'(obs_cr), 32'd0);
      chk("t4_byte_held", 32'(obs_bo), 32'(c1));
    end
    drive(1, c3, 4'd8, 0, 1); step();
    chk("t4_cr_resume", 32'(obs_cr), 32'd1);
    drive(0, 8'h00, 4'd0, 0, 1); step();
    chk("t4_byte2", 32'(obs_bo), 32'(c2));
    step();
    chk("t4_byte3", 32'(obs_bo), 32'(c3));
    step();
    chk("t4_bv_drop", 32'(obs_bv), 32'd0);

    drive(1, 8'h15, 4'd5, 0, 1); step();
    reset = 1'b1;
    drive(0, 8'h00, 4'd0, 0, 1); step();
    reset = 1'b0;
    drive(0, 8'h00, 4'd0, 1, 1); step();
    drive(0, 8'h00, 4'd0, 0, 1); step();
    chk("t5_fd", 32'(obs_fd), 32'd1);
    chk("t5_no_byte", 32'(obs_bv), 32'd0);
    step();
    chk("t5_fd_once", 32'(obs_fd), 32'd0);
    chk("t5_no_byte2", 32'(obs_bv), 32'd0);

`ifdef HUFF_PACK_STATS_EN
    do_reset();
    t1();
    t3();
    chk("stats_bits", 32'(total_bits), 32'd10);
    chk("stats_bytes", 32'(total_bytes), 32'd2);
`endif

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 599) == 0);
      drive(($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0));
      step();
    end
    reset = 1'b0;

    drive(0, 8'h00, 4'd0, 1, 1); step();
    drive(0, 8'h00, 4'd0, 0, 1);
    budget = 64;
    while (mflush && budget > 0) begin
      step();
      budget--;
    end
    chk("drain_done", 32'(mflush), 32'd0);
    chk("drain_empty", 32'(bq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
